// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address-split helpers for set_assoc_cache
// Contents:
//   state_t          controller states {IDLE, FILL, WRITE, RESP}
//   off_w/idx_w/tag_w byte-address field widths
//   plru_w           tree-PLRU bits per set (WAYS-1, at least 1 so the vector exists)
//   way_w            way-index width (at least 1)
package cache_pkg;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - idx_w(sets) - off_w(line_words);
    endfunction

    function automatic int plru_w(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - tree pseudo-LRU victim selection and update for one set
// Ports:
//   bits_in    current tree bits of the set (node 0 = root, children 2n+1 / 2n+2)
//   access_way way being accessed this cycle
//   victim     way the tree currently points at
//   bits_out   tree bits after touching access_way
// A node bit of 1 points the victim walk at the upper half of its subtree.
module plru_tree
    import cache_pkg::*;
#(
    parameter  int WAYS = 2,
    localparam int PW   = plru_w(WAYS),
    localparam int WW   = way_w(WAYS)
) (
    input  logic [PW-1:0] bits_in,
    input  logic [WW-1:0] access_way,
    output logic [WW-1:0] victim,
    output logic [PW-1:0] bits_out
);

    localparam int LEVELS = $clog2(WAYS);

    int   node;
    logic dir;

    always_comb begin
        victim   = '0;
        bits_out = bits_in;
        node     = 0;
        dir      = 1'b0;
        // Follow the pointers from the root down to a leaf.
        for (int l = 0; l < LEVELS; l++) begin
            dir = 1'b0;
            for (int n = 0; n < PW; n++) begin
                if (n == node) dir = bits_in[n];
            end
            victim[LEVELS-1-l] = dir;
            node = 2 * node + 1 + int'(dir);
        end
        // Along the accessed way's path, point every node away from it.
        node = 0;
        for (int l = 0; l < LEVELS; l++) begin
            dir = access_way[LEVELS-1-l];
            for (int n = 0; n < PW; n++) begin
                if (n == node) bits_out[n] = ~dir;
            end
            node = 2 * node + 1 + int'(dir);
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way write-through, no-write-allocate data cache with tree PLRU
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   rd_en_in, wr_en_in, adr_in,       requester side (levels held until ready_out)
//   wdata_in, inv_all_in
//   rdata_out, ready_out              response (ready_out is a one-cycle pulse)
//   sram_rd_en_out, sram_wr_en_out,   SRAM side, registered and held until sram_ready_in
//   sram_adr_out, sram_wdata_out
//   sram_read_data_in, sram_ready_in  fill line (word 0 in LSBs) and completion pulse
//   hit_cnt_out, rd_cnt_out           read statistics, only with CACHE_STATS_EN defined
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2,
    parameter int ADDR_W     = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en_in,
    input  logic                     wr_en_in,
    input  logic [ADDR_W-1:0]        adr_in,
    input  logic [31:0]              wdata_in,
    input  logic                     inv_all_in,
    output logic [31:0]              rdata_out,
    output logic                     ready_out,
    output logic                     sram_rd_en_out,
    output logic                     sram_wr_en_out,
    output logic [ADDR_W-1:0]        sram_adr_out,
    output logic [31:0]              sram_wdata_out,
    input  logic [32*LINE_WORDS-1:0] sram_read_data_in,
    input  logic                     sram_ready_in
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]              hit_cnt_out,
    output logic [31:0]              rd_cnt_out
`endif
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int PW    = plru_w(WAYS);
    localparam int WW    = way_w(WAYS);
    localparam int SEL_W = OFF_W - 2;

    state_t state, state_next;

    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      data_q  [WAYS][SETS][LINE_WORDS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [PW-1:0]    plru_q  [SETS];
    logic [WW-1:0]    victim_q;
    logic             resp_rd_q, resp_hit_q;

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [SEL_W-1:0] wsel;
    logic             hit, any_free;
    logic [WW-1:0]    hit_way, free_way, acc_way, plru_victim;
    logic [PW-1:0]    plru_next;
    logic             idle_rd, idle_wr, fill_done;

    assign tag  = adr_in[ADDR_W-1 -: TAG_W];
    assign idx  = adr_in[OFF_W +: IDX_W];
    assign wsel = adr_in[2 +: SEL_W];

    // Both enables high counts as a write.
    assign idle_rd   = (state == IDLE) && rd_en_in && !wr_en_in;
    assign idle_wr   = (state == IDLE) && wr_en_in;
    assign fill_done = (state == FILL) && sram_ready_in;

    // Descending scan so the lowest-index match / free way wins.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        any_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[idx][w]) begin
                any_free = 1'b1;
                free_way = WW'(w);
            end
        end
    end

    // A fill touches the way it is loading; everything else touches the hit way.
    assign acc_way = (state == FILL) ? victim_q : hit_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_in    (plru_q[idx]),
        .access_way (acc_way),
        .victim     (plru_victim),
        .bits_out   (plru_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (wr_en_in)      state_next = WRITE;
                   else if (rd_en_in) state_next = hit ? RESP : FILL;
            FILL:  if (sram_ready_in) state_next = RESP;
            WRITE: if (sram_ready_in) state_next = RESP;
            RESP:                     state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Line storage carries no reset; valid bits alone decide what is cached.
    always_ff @(posedge clk) begin
        if (idle_wr && hit) data_q[hit_way][idx][wsel] <= wdata_in;
        if (fill_done) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                data_q[victim_q][idx][k] <= sram_read_data_in[32*k +: 32];
            end
            tag_q[victim_q][idx] <= tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            victim_q       <= '0;
            resp_rd_q      <= 1'b0;
            resp_hit_q     <= 1'b0;
            rdata_out      <= '0;
            ready_out      <= 1'b0;
            sram_rd_en_out <= 1'b0;
            sram_wr_en_out <= 1'b0;
            sram_adr_out   <= '0;
            sram_wdata_out <= '0;
`ifdef CACHE_STATS_EN
            hit_cnt_out    <= '0;
            rd_cnt_out     <= '0;
`endif
        end else begin
            // Outputs are registered from the next state so they stay glitch-free
            // and stable for the whole SRAM transaction.
            ready_out      <= (state_next == RESP);
            sram_rd_en_out <= (state_next == FILL);
            sram_wr_en_out <= (state_next == WRITE);

            if (idle_rd) begin
                resp_rd_q  <= 1'b1;
                resp_hit_q <= hit;
                if (hit) begin
                    rdata_out <= data_q[hit_way][idx][wsel];
                end else begin
                    victim_q     <= any_free ? free_way : plru_victim;
                    sram_adr_out <= {adr_in[ADDR_W-1:OFF_W], OFF_W'(0)};
                end
            end
            if (idle_wr) begin
                resp_rd_q      <= 1'b0;
                resp_hit_q     <= 1'b0;
                sram_adr_out   <= adr_in;
                sram_wdata_out <= wdata_in;
            end
            if (((idle_rd || idle_wr) && hit) || fill_done) plru_q[idx] <= plru_next;

            if (fill_done) begin
                for (int k = 0; k < LINE_WORDS; k++) begin
                    if (SEL_W'(k) == wsel) rdata_out <= sram_read_data_in[32*k +: 32];
                end
            end

            // Invalidate beats a coinciding fill: the line lands but stays invalid.
            if (inv_all_in) begin
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end else if (fill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
            end

`ifdef CACHE_STATS_EN
            if (state == RESP && resp_rd_q) begin
                rd_cnt_out <= rd_cnt_out + 32'd1;
                if (resp_hit_q) hit_cnt_out <= hit_cnt_out + 32'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - randomized self-checking bench for set_assoc_cache (4 ways, 8 sets)
module tb_set_assoc_cache;

    localparam int WAYS = 4;
    localparam int SETS = 8;
    localparam int LW   = 2;
    localparam int AW   = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en_in, wr_en_in, inv_all_in;
    logic [AW-1:0] adr_in;
    logic [31:0]   wdata_in, rdata_out, sram_wdata_out;
    logic          ready_out, sram_rd_en_out, sram_wr_en_out, sram_ready_in;
    logic [AW-1:0] sram_adr_out;
    logic [32*LW-1:0] sram_read_data_in;
`ifdef CACHE_STATS_EN
    logic [31:0]   hit_cnt_out, rd_cnt_out;
`endif

    set_assoc_cache #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .rd_en_in          (rd_en_in),
        .wr_en_in          (wr_en_in),
        .adr_in            (adr_in),
        .wdata_in          (wdata_in),
        .inv_all_in        (inv_all_in),
        .rdata_out         (rdata_out),
        .ready_out         (ready_out),
        .sram_rd_en_out    (sram_rd_en_out),
        .sram_wr_en_out    (sram_wr_en_out),
        .sram_adr_out      (sram_adr_out),
        .sram_wdata_out    (sram_wdata_out),
        .sram_read_data_in (sram_read_data_in),
        .sram_ready_in     (sram_ready_in)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt_out       (hit_cnt_out),
        .rd_cnt_out        (rd_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference memory: explicit writes override a fixed address hash.
    logic [31:0] mem [int];
    function automatic logic [31:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference cache: per-set tags/valids plus the PLRU tree walked by halving way ranges.
    bit       m_valid [SETS][WAYS];
    int       m_tag   [SETS][WAYS];
    bit       m_tree  [SETS][WAYS-1];
    int       m_reads, m_hits;

    function automatic int m_pick(input int s);
        int lo, hi, n, mid;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        lo = 0; hi = WAYS; n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_tree[s][n]) begin lo = mid; n = 2 * n + 2; end
            else              begin hi = mid; n = 2 * n + 1; end
        end
        return lo;
    endfunction

    function automatic void m_touch(input int s, input int w);
        int lo, hi, n, mid;
        lo = 0; hi = WAYS; n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w >= mid) begin m_tree[s][n] = 1'b0; lo = mid; n = 2 * n + 2; end
            else          begin m_tree[s][n] = 1'b1; hi = mid; n = 2 * n + 1; end
        end
    endfunction

    function automatic void m_inval();
        for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    endfunction

    function automatic void m_reset();
        m_inval();
        for (int s = 0; s < SETS; s++) for (int n = 0; n < WAYS - 1; n++) m_tree[s][n] = 1'b0;
        m_reads = 0;
        m_hits  = 0;
    endfunction

    // SRAM responder state (written only by the responder process).
    int          n_fill = 0, n_wr = 0, last_l = 0, wait_cnt = 0;
    int          obs_fill_adr = 0, obs_wr_adr = 0;
    logic [31:0] obs_wr_data = '0;
    // Requests from the main thread to the responder.
    bit          resp_en = 1'b1, stray_ready = 1'b0, inv_req_main = 1'b0, inv_on_fill = 1'b0;

    initial begin
        sram_ready_in     = 1'b0;
        sram_read_data_in = '0;
        inv_all_in        = 1'b0;
        forever begin
            @(negedge clk);
            inv_all_in = inv_req_main;
            if (!resp_en) begin
                sram_ready_in = stray_ready;
                wait_cnt      = 0;
            end else begin
                sram_ready_in = 1'b0;
                if (sram_rd_en_out || sram_wr_en_out) begin
                    if (wait_cnt == 0) begin
                        wait_cnt = $urandom_range(1, 4);
                        last_l   = wait_cnt;
                    end
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        sram_ready_in = 1'b1;
                        if (sram_rd_en_out) begin
                            obs_fill_adr = int'(sram_adr_out);
                            for (int k = 0; k < LW; k++)
                                sram_read_data_in[32*k +: 32] = mem_rd(obs_fill_adr + 4 * k);
                            n_fill++;
                            if (inv_on_fill) inv_all_in = 1'b1;
                        end else begin
                            obs_wr_adr  = int'(sram_adr_out);
                            obs_wr_data = sram_wdata_out;
                            n_wr++;
                        end
                    end
                end
            end
        end
    end

    logic [31:0] last_rd = '0;

    task automatic access(input bit wr, input int adr, input logic [31:0] wd, output int fills);
        int s, t, hw, v, lat, f0, w0;
        bit hit;
        logic [31:0] rd;
        s = (adr >> 3) % SETS;
        t = adr >> 6;
        hit = 1'b0; hw = 0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1'b1; hw = w; end
        @(posedge clk);
        @(negedge clk);
        f0 = n_fill; w0 = n_wr;
        adr_in = AW'(adr); wdata_in = wd; rd_en_in = !wr; wr_en_in = wr;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready_out && lat < 40);
        rd = rdata_out;
        rd_en_in = 1'b0; wr_en_in = 1'b0;
        check("ready", ready_out, 1);
        fills = n_fill - f0;
        if (wr) begin
            mem[adr] = wd;
            check("wr_sram_cnt", n_wr - w0, 1);
            check("wr_no_fill", fills, 0);
            check("wr_adr", obs_wr_adr, adr);
            check("wr_data", obs_wr_data, wd);
            check("wr_lat", lat, last_l + 1);
            check("wr_rdata_hold", rd, last_rd);
            if (hit) m_touch(s, hw);
        end else begin
            check("rd_data", rd, mem_rd(adr));
            check("rd_fill", fills, hit ? 0 : 1);
            check("rd_no_wr", n_wr - w0, 0);
            if (hit) begin
                check("hit_lat", lat, 1);
                m_touch(s, hw);
                m_hits++;
            end else begin
                check("fill_adr", obs_fill_adr, adr & ~7);
                check("miss_lat", lat, last_l + 1);
                v = m_pick(s);
                m_valid[s][v] = 1'b1;
                m_tag[s][v]   = t;
                m_touch(s, v);
                if (inv_on_fill) m_inval();
            end
            m_reads++;
            last_rd = rd;
        end
        inv_on_fill = 1'b0;
    endtask

    task automatic inv_pulse();
        inv_req_main = 1'b1;
        @(posedge clk); #1;
        inv_req_main = 1'b0;
        m_inval();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f, k, a;
        bit seen;
        rst = 1'b1; rd_en_in = 1'b0; wr_en_in = 1'b0; adr_in = '0; wdata_in = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready_out, 0);
        check("rst_rdata", rdata_out, 0);
        check("rst_sram_rd", sram_rd_en_out, 0);
        check("rst_sram_wr", sram_wr_en_out, 0);
        check("rst_sram_adr", sram_adr_out, 0);
`ifdef CACHE_STATS_EN
        check("rst_rd_cnt", rd_cnt_out, 0);
        check("rst_hit_cnt", hit_cnt_out, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Cold miss then sibling-word hit.
        mem[32'h100] = 32'hAAAA_AAAA;
        mem[32'h104] = 32'hBBBB_BBBB;
        access(0, 32'h100, 0, f);
        check("t1_miss_data", last_rd, 32'hAAAA_AAAA);
        access(0, 32'h104, 0, f);
        check("t1_hit_data", last_rd, 32'hBBBB_BBBB);
        check("t1_hit_nofill", f, 0);

        // Five tags into set 3: the fifth fill evicts way 0's tag.
        for (int t = 8; t < 13; t++) access(0, (t << 6) | 32'h18, 0, f);
        access(0, (8 << 6) | 32'h18, 0, f);
        check("t2_evicted", f, 1);

        // Write hit, then write miss (no allocate).
        access(1, 32'h104, 32'h1234_5678, f);
        access(0, 32'h104, 0, f);
        check("t3_write_hit_data", last_rd, 32'h1234_5678);
        check("t3_write_hit_cached", f, 0);
        access(1, 32'h2040, 32'hCAFE_F00D, f);
        access(0, 32'h2040, 0, f);
        check("t3_no_alloc", f, 1);
        check("t3_miss_data", last_rd, 32'hCAFE_F00D);

        // Invalidate on the fill completion edge.
        inv_on_fill = 1'b1;
        access(0, 32'h3080, 0, f);
        access(0, 32'h3080, 0, f);
        check("t4_inv_refill", f, 1);

        // Reset in the middle of a fill.
        resp_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        adr_in = AW'(32'h3800); rd_en_in = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!sram_rd_en_out && k < 10);
        check("t5_fill_started", sram_rd_en_out, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_sram_rd", sram_rd_en_out, 0);
        check("t5_rst_ready", ready_out, 0);
        @(negedge clk);
        rst = 1'b0; rd_en_in = 1'b0;
        @(posedge clk); #1;
        stray_ready = 1'b1;
        @(posedge clk); #1;
        stray_ready = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; seen |= ready_out | sram_rd_en_out; end
        check("t5_stray_ignored", seen, 0);
        resp_en = 1'b1;
        m_reset();
        last_rd = '0;

        // 3 misses + 5 hits, then two writes.
        access(0, 32'h400, 0, f);
        access(0, 32'h480, 0, f);
        access(0, 32'h500, 0, f);
        access(0, 32'h404, 0, f);
        access(0, 32'h484, 0, f);
        access(0, 32'h504, 0, f);
        access(0, 32'h400, 0, f);
        access(0, 32'h480, 0, f);
        access(1, 32'h400, 32'h0BAD_BEEF, f);
        access(1, 32'h600, 32'h5555_AAAA, f);
`ifdef CACHE_STATS_EN
        check("t6_rd_cnt", rd_cnt_out, 8);
        check("t6_hit_cnt", hit_cnt_out, 5);
`endif
        check("t6_model_hits", m_hits, 5);

        // Random traffic over a few conflicting tags.
        for (int i = 0; i < 250; i++) begin
            a = ($urandom_range(0, 5) << 6) | ($urandom_range(0, SETS - 1) << 3) | ($urandom_range(0, 1) << 2);
            if ($urandom_range(0, 39) == 0) inv_pulse();
            if ($urandom_range(0, 9) < 3) begin
                access(1, a, $urandom, f);
            end else begin
                inv_on_fill = ($urandom_range(0, 15) == 0);
                access(0, a, 0, f);
            end
        end
`ifdef CACHE_STATS_EN
        check("rand_rd_cnt", rd_cnt_out, m_reads);
        check("rand_hit_cnt", hit_cnt_out, m_hits);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
